// File: rtl/dense_piso.sv
// Parallel-in/serial-out window unloader: accepts NUM_SR_ROWS x P_SR_DEPTH bytes at once, emits them byte 0 first.
// Optional shift_last output is enabled by defining DENSE_PISO_LAST_EN.
`timescale 1ns/1ps

module dense_piso #(
   parameter int P_SR_DEPTH  = -1,
   parameter int NUM_SR_ROWS = -1,
   localparam int N          = P_SR_DEPTH * NUM_SR_ROWS,
   localparam int CNT_W      = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [8*N-1:0] p_window_in,
   input  logic           load_valid,
   output logic           load_ready,
   output logic [7:0]     shift_out,
   output logic           shift_valid,
`ifdef DENSE_PISO_LAST_EN
   output logic           shift_last,
`endif
   input  logic           shift_ready
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [8*N-1:0]   sr;
   logic             is_last;
   logic             load_fire;

   assign is_last     = (cnt == LAST);
   assign load_ready  = ~reset & ((state == IDLE) | ((state == SHIFT) & is_last & shift_ready));
   assign load_fire   = load_valid & load_ready;
   assign shift_valid = (state == SHIFT);
   assign shift_out   = sr[7:0];

`ifdef DENSE_PISO_LAST_EN
   assign shift_last  = shift_valid & is_last;
`endif

   // A logical right shift rather than a {8'h00, sr[8N-1:8]} slice keeps N==1 legal.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         sr    <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
         case (state)
            IDLE: begin
               if (load_fire) begin
                  sr    <= p_window_in;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (shift_ready) begin
                  if (!is_last) begin
                     sr  <= sr >> 8;
                     cnt <= cnt + 1'b1;
                  end else if (load_fire) begin
                     sr  <= p_window_in;
                     cnt <= '0;
                  end else begin
                     sr    <= sr >> 8;
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dense_piso.sv
// Self-checking bench for dense_piso: a 3x3 instance and a 1x1 instance checked against a byte-queue model.
// Defining DENSE_PISO_LAST_EN also checks shift_last.
`timescale 1ns/1ps

module tb_dense_piso;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic [71:0] win9;
   logic        lv9, lr9, sv9, srdy9;
   logic [7:0]  so9;
   logic [7:0]  win1;
   logic        lv1, lr1, sv1, srdy1;
   logic [7:0]  so1;
`ifdef DENSE_PISO_LAST_EN
   logic        sl9, sl1;
`endif

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  q9[$];
   logic [7:0]  q1[$];

   dense_piso #(.P_SR_DEPTH(3), .NUM_SR_ROWS(3)) dut9 (
      .clock(clock), .reset(reset), .p_window_in(win9), .load_valid(lv9), .load_ready(lr9),
      .shift_out(so9), .shift_valid(sv9),
`ifdef DENSE_PISO_LAST_EN
      .shift_last(sl9),
`endif
      .shift_ready(srdy9));

   dense_piso #(.P_SR_DEPTH(1), .NUM_SR_ROWS(1)) dut1 (
      .clock(clock), .reset(reset), .p_window_in(win1), .load_valid(lv1), .load_ready(lr1),
      .shift_out(so1), .shift_valid(sv1),
`ifdef DENSE_PISO_LAST_EN
      .shift_last(sl1),
`endif
      .shift_ready(srdy1));

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [71:0] mk9(input logic [7:0] base);
      logic [71:0] w;
      for (int k = 0; k < 9; k++) w[8*k +: 8] = base + 8'(k);
      return w;
   endfunction

   // Model: a window is a queue of pending bytes; the head is what must be on the wire.
   always @(negedge clock) begin
      bit exp_lr9, exp_lr1;
      if (reset) begin
         check("m_rst_valid9", {31'd0, sv9}, 0);
         check("m_rst_out9", {24'd0, so9}, 0);
         check("m_rst_ready9", {31'd0, lr9}, 0);
         check("m_rst_valid1", {31'd0, sv1}, 0);
         check("m_rst_ready1", {31'd0, lr1}, 0);
         q9.delete();
         q1.delete();
      end else begin
         exp_lr9 = (q9.size() == 0) || (q9.size() == 1 && srdy9);
         check("m_valid9", {31'd0, sv9}, {31'd0, q9.size() != 0});
         check("m_out9", {24'd0, so9}, (q9.size() != 0) ? {24'd0, q9[0]} : 32'd0);
         check("m_ready9", {31'd0, lr9}, {31'd0, exp_lr9});
`ifdef DENSE_PISO_LAST_EN
         check("m_last9", {31'd0, sl9}, {31'd0, q9.size() == 1});
`endif
         if (q9.size() != 0 && srdy9) void'(q9.pop_front());
         if (lv9 && exp_lr9) for (int k = 0; k < 9; k++) q9.push_back(win9[8*k +: 8]);

         exp_lr1 = (q1.size() == 0) || (q1.size() == 1 && srdy1);
         check("m_valid1", {31'd0, sv1}, {31'd0, q1.size() != 0});
         check("m_out1", {24'd0, so1}, (q1.size() != 0) ? {24'd0, q1[0]} : 32'd0);
         check("m_ready1", {31'd0, lr1}, {31'd0, exp_lr1});
`ifdef DENSE_PISO_LAST_EN
         check("m_last1", {31'd0, sl1}, {31'd0, q1.size() == 1});
`endif
         if (q1.size() != 0 && srdy1) void'(q1.pop_front());
         if (lv1 && exp_lr1) q1.push_back(win1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] got_b[9];
      int got, stall;

      lv9 = 1'b0; srdy9 = 1'b1; win9 = '0;
      lv1 = 1'b0; srdy1 = 1'b1; win1 = '0;
      repeat (3) tick();

      // Reset state and same-cycle release
      check("rst_ready9", {31'd0, lr9}, 0);
      check("rst_valid9", {31'd0, sv9}, 0);
      check("rst_out9", {24'd0, so9}, 0);
      reset = 1'b0;
      #1;
      check("release_ready9", {31'd0, lr9}, 1);
      check("release_ready1", {31'd0, lr1}, 1);
      tick();

      // T2: basic 3x3 window, no backpressure
      win9 = mk9(8'h01); lv9 = 1'b1;
      tick();
      lv9 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check("t2_valid", {31'd0, sv9}, 1);
         check("t2_byte", {24'd0, so9}, i + 1);
`ifdef DENSE_PISO_LAST_EN
         check("t2_last", {31'd0, sl9}, {31'd0, i == 8});
`endif
         tick();
      end
      check("t2_idle_valid", {31'd0, sv9}, 0);
      check("t2_idle_out", {24'd0, so9}, 0);

      // T3/T6: stalls of 3 cycles on beats 2, 5 and the last beat
      win9 = mk9(8'h01); lv9 = 1'b1;
      tick();
      lv9 = 1'b0;
      got = 0; stall = 0;
      for (int cyc = 0; cyc < 60 && got < 9; cyc++) begin
         if ((got == 2 || got == 5 || got == 8) && stall < 3) begin
            srdy9 = 1'b0;
            stall++;
         end else begin
            srdy9 = 1'b1;
         end
         #1;
         if (got == 8 && !srdy9) begin
            check("t6_hold_out", {24'd0, so9}, 32'h09);
`ifdef DENSE_PISO_LAST_EN
            check("t6_last_held", {31'd0, sl9}, 1);
`endif
         end
         if (sv9 && srdy9) begin
            got_b[got] = so9;
            got++;
            stall = 0;
         end
         tick();
      end
      srdy9 = 1'b1;
      check("t3_count", got, 9);
      for (int i = 0; i < 9; i++) check("t3_order", {24'd0, got_b[i]}, i + 1);

      // T4: back-to-back windows with load_valid held
      win9 = mk9(8'h10); lv9 = 1'b1;
      tick();
      win9 = mk9(8'h20);
      for (int i = 0; i < 9; i++) begin
         check("t4_a_valid", {31'd0, sv9}, 1);
         check("t4_a_byte", {24'd0, so9}, 32'h10 + i);
         check("t4_a_ready", {31'd0, lr9}, {31'd0, i == 8});
         tick();
      end
      lv9 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check("t4_b_valid", {31'd0, sv9}, 1);
         check("t4_b_byte", {24'd0, so9}, 32'h20 + i);
         tick();
      end
      check("t4_idle_valid", {31'd0, sv9}, 0);

      // T1: reset mid-window
      win9 = mk9(8'h30); lv9 = 1'b1;
      tick();
      lv9 = 1'b0;
      tick();
      tick();
      check("t1_pre_byte", {24'd0, so9}, 32'h32);
      reset = 1'b1;
      #1;
      check("t1_valid", {31'd0, sv9}, 0);
      check("t1_out", {24'd0, so9}, 0);
      check("t1_ready", {31'd0, lr9}, 0);
`ifdef DENSE_PISO_LAST_EN
      check("t6_rst_last", {31'd0, sl9}, 0);
`endif
      tick();
      reset = 1'b0;
      #1;
      check("t1_release_ready", {31'd0, lr9}, 1);
      tick();
      check("t1_discarded", {31'd0, sv9}, 0);

      // T5: N==1 continuous loads
      win1 = 8'hAA; lv1 = 1'b1;
      tick();
      check("t5_aa", {24'd0, so1}, 32'hAA);
      check("t5_ready", {31'd0, lr1}, 1);
`ifdef DENSE_PISO_LAST_EN
      check("t5_last_aa", {31'd0, sl1}, 1);
`endif
      win1 = 8'hBB;
      tick();
      check("t5_bb", {24'd0, so1}, 32'hBB);
      check("t5_bb_valid", {31'd0, sv1}, 1);
      win1 = 8'hCC;
      tick();
      check("t5_cc", {24'd0, so1}, 32'hCC);
`ifdef DENSE_PISO_LAST_EN
      check("t5_last_cc", {31'd0, sl1}, 1);
`endif
      lv1 = 1'b0;
      tick();
      check("t5_idle_valid", {31'd0, sv1}, 0);
      check("t5_idle_out", {24'd0, so1}, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
